// File: rtl/key_debouncer.sv
`timescale 1ns/1ps
// key_debouncer: per-channel push-button debouncer.
// Each active-low raw key is synchronized by two flops, then a per-channel counter
// must see STABLE_CYCLES consecutive samples of a new level before the debounced
// level flips. Press and release strobes are registered and line up with the
// first cycle of the new debounced level.
module key_debouncer #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned STABLE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] key_n,
  output logic [WIDTH-1:0] pressed,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic             any_pressed
);

  localparam int unsigned     CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;

  // Two-flop synchronizer; resets to the released level (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= key_n;
      sync_q2 <= sync_q1;
    end
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_chan
    logic [CNT_W-1:0] cnt_q;
    logic             pressed_q;
    logic             press_q;
    logic             release_q;
    logic             differ_c;
    logic             accept_c;

    // Synced sample (inverted to 1 = pressed) disagrees with the debounced level.
    assign differ_c = (~sync_q2[i]) != pressed_q;
    // Last stable sample needed: the level flips at the coming edge.
    assign accept_c = differ_c && (cnt_q == CNT_LAST);

    // Stability counter, debounced level and edge strobes for this channel.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q     <= '0;
        pressed_q <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= accept_c && !pressed_q;
        release_q <= accept_c && pressed_q;
        if (!differ_c || accept_c) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        if (accept_c) begin
          pressed_q <= ~pressed_q;
        end
      end
    end

    assign pressed[i]       = pressed_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
  end

  // Summary flag straight off the registered levels.
  assign any_pressed = |pressed;

endmodule

// File: tb/tb_key_debouncer.sv
`timescale 1ns/1ps
// tb_key_debouncer: table-driven vectors plus hand sequences, checked through an
// expectation queue stamped with the clock-edge count at which each result is due.
module tb_key_debouncer;

  localparam int unsigned W  = 4;
  localparam int unsigned SC = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] key_n = '1;
  logic [W-1:0] pressed;
  logic [W-1:0] press_pulse;
  logic [W-1:0] release_pulse;
  logic         any_pressed;

  key_debouncer #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_n         (key_n),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .any_pressed   (any_pressed)
  );

  always #5 clk = ~clk;

  // Count of rising edges seen so far.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  typedef struct packed {
    logic [3:0] p;
    logic [3:0] pp;
    logic [3:0] rp;
    logic       any;
  } outs_t;

  typedef struct {
    int unsigned due;
    outs_t       exp;
    string       name;
  } sb_t;

  typedef struct {
    logic [3:0]  key;
    int unsigned adv;
    logic [3:0]  p;
    logic [3:0]  pp;
    logic [3:0]  rp;
  } vec_t;

  sb_t  sbq[$];
  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic outs_t mk(input logic [3:0] p, input logic [3:0] pp, input logic [3:0] rp);
    outs_t o;
    o.p   = p;
    o.pp  = pp;
    o.rp  = rp;
    o.any = |p;
    return o;
  endfunction

  function automatic outs_t actual();
    outs_t o;
    o.p   = pressed;
    o.pp  = press_pulse;
    o.rp  = release_pulse;
    o.any = any_pressed;
    return o;
  endfunction

  task automatic check(input string name, input outs_t act, input outs_t exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @cyc %0d: got pressed=%b press=%b release=%b any=%b, expected pressed=%b press=%b release=%b any=%b",
               name, cyc, act.p, act.pp, act.rp, act.any, exp.p, exp.pp, exp.rp, exp.any);
    end
  endtask

  task automatic expect_in(input int unsigned off, input outs_t exp, input string name);
    sb_t e;
    e.due  = cyc + off;
    e.exp  = exp;
    e.name = name;
    sbq.push_back(e);
  endtask

  // Advance n rising edges and return 1 ns after the last one.
  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic [3:0] key, input int unsigned adv,
                              input logic [3:0] p, input logic [3:0] pp, input logic [3:0] rp);
    vec_t v;
    v.key = key;
    v.adv = adv;
    v.p   = p;
    v.pp  = pp;
    v.rp  = rp;
    vecs.push_back(v);
  endfunction

  // Compare outputs mid-cycle against expectations due at this edge count.
  always @(negedge clk) begin : monitor
    sb_t e;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      if (e.due < cyc) begin
        n_total++;
        $display("FAIL %s: check slot cyc %0d missed (now %0d)", e.name, e.due, cyc);
      end else begin
        check(e.name, actual(), e.exp);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    outs_t zero;
    int unsigned r0;
    zero = mk(4'h0, 4'h0, 4'h0);

    // Rows: drive key, advance adv edges, expect outputs (adv counted from the drive).
    add(4'hF,  1, 4'h0, 4'h0, 4'h0);
    add(4'hE,  9, 4'h0, 4'h0, 4'h0);
    add(4'hE,  1, 4'h1, 4'h1, 4'h0);
    add(4'hE,  1, 4'h1, 4'h0, 4'h0);
    add(4'hF,  9, 4'h1, 4'h0, 4'h0);
    add(4'hF,  1, 4'h0, 4'h0, 4'h1);
    add(4'hF,  1, 4'h0, 4'h0, 4'h0);
    add(4'h3,  9, 4'h0, 4'h0, 4'h0);
    add(4'h3,  1, 4'hC, 4'hC, 4'h0);
    add(4'h3,  1, 4'hC, 4'h0, 4'h0);
    add(4'hF, 10, 4'h0, 4'h0, 4'hC);
    add(4'hF,  1, 4'h0, 4'h0, 4'h0);
    add(4'h6, 10, 4'h9, 4'h9, 4'h0);
    add(4'h7, 10, 4'h8, 4'h0, 4'h1);
    add(4'h7,  1, 4'h8, 4'h0, 4'h0);
    add(4'hF, 10, 4'h0, 4'h0, 4'h8);
    add(4'hF,  1, 4'h0, 4'h0, 4'h0);

    key_n = '1;
    rst_n = 1'b0;
    step(2);
    check("reset_state", actual(), zero);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      key_n = vecs[i].key;
      expect_in(vecs[i].adv, mk(vecs[i].p, vecs[i].pp, vecs[i].rp), $sformatf("vec%0d", i));
      step(vecs[i].adv);
    end

    // Bounce: 7 low samples, 1 high, then held low.
    expect_in(9,  zero, "bounce_9");
    expect_in(10, zero, "bounce_7mark");
    expect_in(11, zero, "bounce_11");
    expect_in(17, zero, "bounce_early");
    expect_in(18, mk(4'h2, 4'h2, 4'h0), "bounce_accept");
    expect_in(19, mk(4'h2, 4'h0, 4'h0), "bounce_single");
    key_n = 4'b1101;
    step(7);
    key_n = 4'b1111;
    step(1);
    key_n = 4'b1101;
    step(11);
    key_n = 4'hF;
    expect_in(10, mk(4'h0, 4'h0, 4'h2), "bounce_release");
    expect_in(11, zero, "bounce_idle");
    step(11);

    // Reset mid-count with ch2 already pressed and ch0 counting.
    key_n = 4'b1011;
    expect_in(10, mk(4'h4, 4'h4, 4'h0), "pre_reset_press");
    step(12);
    key_n = 4'b1010;
    step(7);
    rst_n = 1'b0;
    #1;
    check("reset_async", actual(), zero);
    step(2);
    check("reset_hold", actual(), zero);
    rst_n = 1'b1;
    r0 = cyc;
    expect_in(9,  zero, "post_reset_early");
    expect_in(10, mk(4'h5, 4'h5, 4'h0), "post_reset_press");
    expect_in(11, mk(4'h5, 4'h0, 4'h0), "post_reset_single");
    step(11);
    if (cyc - r0 != 11) begin
      n_total++;
      $display("FAIL reset_timing: got %0d edges expected 11", cyc - r0);
    end
    key_n = 4'hF;
    expect_in(10, mk(4'h0, 4'h0, 4'h5), "post_reset_release");
    expect_in(11, zero, "post_reset_idle");
    step(11);

    // Short glitches: one low sample every 4 cycles must never be accepted.
    for (int i = 0; i < 200; i++) begin
      key_n = (i % 4 == 0) ? 4'b1110 : 4'b1111;
      expect_in(1, zero, "glitch");
      step(1);
    end
    key_n = 4'hF;
    for (int i = 0; i < 12; i++) begin
      expect_in(1, zero, "glitch_tail");
      step(1);
    end

    step(3);
    while (sbq.size() > 0) begin
      sb_t e;
      e = sbq.pop_front();
      n_total++;
      $display("FAIL %s: got unchecked expected checked at cyc %0d", e.name, e.due);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of independent key channels.
REQ-002 SHALL have parameter STABLE_CYCLES, default 1_000_000: consecutive stable samples required to accept a level change (20 ms at 50 MHz); legal range 2 or more.
REQ-003 SHALL have port clk  input  1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous assert and active-low.
REQ-005 SHALL have port key_n  input  WIDTH: raw, asynchronous, bouncing push-button pins; 0 = pressed.
REQ-006 SHALL have port pressed  output  WIDTH: debounced level per channel; 1 = pressed.
REQ-007 SHALL have port press_pulse  output  WIDTH: one-cycle strobe on each accepted released-to-pressed change.
REQ-008 SHALL have port release_pulse  output  WIDTH: one-cycle strobe on each accepted pressed-to-released change.
REQ-009 SHALL have port any_pressed  output  1: OR-reduction of pressed.

Function
REQ-010 SHALL pass each key_n bit through a two-flop synchronizer before any other logic uses it; the second-stage output is the "synced sample".
REQ-011 SHALL keep one debounce counter per channel, width $clog2(STABLE_CYCLES+1), with no counter shared between channels.
REQ-012 SHALL clear a channel's counter on any cycle where its synced sample, inverted, equals its current pressed bit.
REQ-013 SHALL increment a channel's counter by 1 on each cycle where its synced sample, inverted, differs from pressed.
REQ-014 SHALL, on the cycle a channel's counter equals STABLE_CYCLES-1 and the sample still differs: toggle pressed at the next edge, clear the counter at the same edge, and never let the counter exceed STABLE_CYCLES-1 (no wrap-around).
REQ-015 SHALL make any single differing-then-agreeing sample (a bounce) restart the count from 0; progress is never retained across a bounce.
REQ-016 SHALL give a total latency of exactly STABLE_CYCLES+2 clk edges from the first edge sampling the new, thereafter-stable key_n level to the edge where pressed changes.
REQ-017 SHALL register press_pulse[i] and assert it high for exactly one cycle, coincident with the first cycle pressed[i] reads 1.
REQ-018 SHALL register release_pulse[i] and assert it high for exactly one cycle, coincident with the first cycle pressed[i] reads 0.
REQ-019 SHALL never assert press_pulse[i] and release_pulse[i] in the same cycle.
REQ-020 SHALL never assert more than one pulse per accepted change.
REQ-021 SHALL process channels fully independently; simultaneous changes on several channels SHALL produce simultaneous pulses on each affected bit.
REQ-022 SHALL drive any_pressed combinationally from the registered pressed vector.
REQ-023 SHALL make the outputs glitch-free register outputs (except any_pressed), suitable to feed the downstream edge-detector and press-hold stages directly.

Reset
REQ-024 SHALL, while rst_n=0, immediately force: synchronizer flops to 1 (released), counters to 0, pressed=0, press_pulse=0, release_pulse=0, any_pressed=0.
REQ-025 SHALL discard debounce progress on reset asserted mid-count; counting SHALL restart from 0 after release.
REQ-026 SHALL treat a key held through reset deassertion as a new press: press_pulse fires after the full STABLE_CYCLES+2 latency.
REQ-027 SHALL resume normal sampling on the first clk rising edge after rst_n deasserts; no extra wait cycles.

Verification (STABLE_CYCLES=8, WIDTH=4)
REQ-028 SHALL cover clean press: key_n[0] 1->0 and held -> pressed[0]=1 and press_pulse[0]=1 for one cycle exactly 10 edges later; any_pressed=1.
REQ-029 SHALL cover bounce rejection: key_n[1] low for 7 cycles, high 1 cycle, then low held -> no pulse at the 7-cycle mark; press_pulse[1] fires 10 edges after the final falling edge.
REQ-030 SHALL cover release: from pressed[0]=1, key_n[0] 0->1 and held -> release_pulse[0] one cycle, pressed[0]=0 after 10 edges, no press_pulse.
REQ-031 SHALL cover simultaneous events: key_n[3:2] both 1->0 on the same edge -> press_pulse=4'b1100 in a single cycle.
REQ-032 SHALL cover reset mid-count: rst_n low for 2 cycles after 5 differing samples, key held -> outputs 0 during reset; press_pulse 10 edges after rst_n rises.
REQ-033 SHALL cover short glitches: 1-cycle low pulses every 4 cycles on key_n[0] for 200 cycles -> pressed, press_pulse and release_pulse stay 0 throughout.
